alu_bus_sequencer: RTL and testbench

ALU_BUS_SEQUENCER -- requirements
Module: alu_bus_sequencer

---
 rtl/alu_bus_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_bus_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_bus_sequencer.sv
// rtl/alu_bus_sequencer.sv - steps one ALU transaction across the raddr/waddr/action bus fields
module alu_bus_sequencer #(
  parameter logic [4:0] IDLE_ADDR = 5'b00000
) (
  input  logic       clk3,
  input  logic       rsthold,
  input  logic       start,
  input  logic [2:0] opsel,
  input  logic [4:0] src_raddr,
  input  logic [4:0] dst_waddr,
  input  logic [1:0] pre_action,
  input  logic       post_sru,
  output logic [4:0] raddr,
  output logic [4:0] waddr,
  output logic [3:0] action,
  output logic       t34,
  output logic       busy,
  output logic       done
);

  // Address 11000 is ALU B when written and ALU Y when read.
  localparam logic [4:0] ALU_REG = 5'b11000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_LOADB,
    S_OP,
    S_STORE,
    S_POST
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] phase;
  logic       accept;
  logic       finish;
  logic       pre_valid;

  // Transaction parameters captured at acceptance so later input changes are ignored.
  logic [2:0] op_q;
  logic [4:0] src_q;
  logic [4:0] dst_q;
  logic       pre_cll_q;
  logic       sru_q;

  // Only CPL (01) and CLL (10) produce a PRE step; 11 is reserved and behaves as none.
  assign pre_valid = (pre_action == 2'b01) || (pre_action == 2'b10);

  // Strobe window is closed for the first half of every step and always while idle.
  assign t34  = (state == S_IDLE) | ~phase[1];
  assign busy = (state != S_IDLE);

  // State, phase and done pulse registers.
  always_ff @(posedge clk3 or posedge rsthold) begin
    if (rsthold) begin
      state <= S_IDLE;
      phase <= 2'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state_nxt != state) || (state == S_IDLE)) begin
        phase <= 2'd0;
      end else begin
        phase <= phase + 2'd1;
      end
      done <= finish;
    end
  end

  // Capture the request fields when a start is accepted.
  always_ff @(posedge clk3 or posedge rsthold) begin
    if (rsthold) begin
      op_q      <= 3'd0;
      src_q     <= 5'd0;
      dst_q     <= 5'd0;
      pre_cll_q <= 1'b0;
      sru_q     <= 1'b0;
    end else if (accept) begin
      op_q      <= opsel;
      src_q     <= src_raddr;
      dst_q     <= dst_waddr;
      pre_cll_q <= pre_action[1];
      sru_q     <= post_sru;
    end
  end

  // Next-state selection and per-step bus field decode; fields depend on state only.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    raddr     = IDLE_ADDR;
    waddr     = IDLE_ADDR;
    action    = 4'b0000;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = pre_valid ? S_PRE : S_LOADB;
        end
      end
      S_PRE: begin
        action = pre_cll_q ? 4'b0010 : 4'b0001;
        if (phase == 2'd3) state_nxt = S_LOADB;
      end
      S_LOADB: begin
        raddr = src_q;
        waddr = ALU_REG;
        if (phase == 2'd3) state_nxt = S_OP;
      end
      S_OP: begin
        raddr = {2'b10, op_q};
        if (phase == 2'd3) state_nxt = S_STORE;
      end
      S_STORE: begin
        raddr = ALU_REG;
        waddr = dst_q;
        if (phase == 2'd3) begin
          if (sru_q) begin
            state_nxt = S_POST;
          end else begin
            state_nxt = S_IDLE;
            finish    = 1'b1;
          end
        end
      end
      S_POST: begin
        action = 4'b0111;
        if (phase == 2'd3) begin
          state_nxt = S_IDLE;
          finish    = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_bus_sequencer.sv
// tb/tb_alu_bus_sequencer.sv - randomized and directed checks of alu_bus_sequencer against a cycle-list model
module tb_alu_bus_sequencer;

  localparam logic [4:0]  IA       = 5'b00000;
  localparam logic [4:0]  ALU_REG  = 5'b11000;
  // Expected vector layout: {raddr, waddr, action, t34, busy, done}
  localparam logic [16:0] IDLE_VEC = {IA, IA, 4'b0000, 1'b1, 1'b0, 1'b0};
  localparam logic [16:0] DONE_VEC = {IA, IA, 4'b0000, 1'b1, 1'b0, 1'b1};

  logic       clk3 = 1'b0;
  logic       rsthold;
  logic       start;
  logic [2:0] opsel;
  logic [4:0] src_raddr;
  logic [4:0] dst_waddr;
  logic [1:0] pre_action;
  logic       post_sru;
  logic [4:0] raddr;
  logic [4:0] waddr;
  logic [3:0] action;
  logic       t34;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  alu_bus_sequencer #(.IDLE_ADDR(IA)) dut (
    .clk3(clk3), .rsthold(rsthold), .start(start), .opsel(opsel),
    .src_raddr(src_raddr), .dst_waddr(dst_waddr), .pre_action(pre_action),
    .post_sru(post_sru), .raddr(raddr), .waddr(waddr), .action(action),
    .t34(t34), .busy(busy), .done(done)
  );

  always #5 clk3 = ~clk3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a queue holding the expected output vector for each upcoming clock.
  logic [16:0] exp_q[$];
  logic [16:0] cmp_exp;
  bit          m_idle;

  task automatic push_step(input logic [4:0] r, input logic [4:0] w, input logic [3:0] a);
    for (int p = 0; p < 4; p++) exp_q.push_back({r, w, a, (p < 2), 1'b1, 1'b0});
  endtask

  task automatic model_accept(input logic [2:0] op, input logic [4:0] src, input logic [4:0] dst,
                              input logic [1:0] pre, input logic sru);
    if (pre == 2'b01) push_step(IA, IA, 4'b0001);
    if (pre == 2'b10) push_step(IA, IA, 4'b0010);
    push_step(src, ALU_REG, 4'b0000);
    push_step({2'b10, op}, IA, 4'b0000);
    push_step(ALU_REG, dst, 4'b0000);
    if (sru) push_step(IA, IA, 4'b0111);
    exp_q.push_back(DONE_VEC);
  endtask

  // Advance the model one clock; a start is taken when the model is idle or on its done clock.
  always @(posedge clk3 or posedge rsthold) begin
    if (rsthold) begin
      exp_q.delete();
    end else begin
      m_idle = (exp_q.size() == 0) || ((exp_q.size() == 1) && exp_q[0][0]);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (m_idle && start) model_accept(opsel, src_raddr, dst_waddr, pre_action, post_sru);
    end
  end

  // Compare every clock outside reset.
  always @(negedge clk3) begin
    if (!rsthold) begin
      cmp_exp = (exp_q.size() > 0) ? exp_q[0] : IDLE_VEC;
      check("cycle_outputs", {15'b0, raddr, waddr, action, t34, busy, done}, {15'b0, cmp_exp});
    end
  end

  logic [4:0] s_r[64];
  logic [4:0] s_w[64];
  logic [3:0] s_a[64];
  logic       s_t[64];
  logic       s_b[64];

  // Record outputs each clock until done; optionally pulse start mid-run or hold it on done.
  task automatic run_cycles(input int guard, input bit hold, output int lat);
    lat = -1;
    for (int c = 0; c < 64; c++) begin
      s_r[c] = raddr; s_w[c] = waddr; s_a[c] = action; s_t[c] = t34; s_b[c] = busy;
      if (done) begin
        lat   = c;
        start = hold;
        break;
      end
      start = (c == guard);
      if (c > 0) begin
        opsel = 3'($urandom); src_raddr = 5'($urandom); dst_waddr = 5'($urandom);
        pre_action = 2'($urandom); post_sru = 1'($urandom);
      end
      @(negedge clk3);
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_tx(input logic [2:0] op, input logic [4:0] src, input logic [4:0] dst,
                       input logic [1:0] pre, input logic sru, input int guard, input bit hold,
                       output int lat);
    opsel = op; src_raddr = src; dst_waddr = dst; pre_action = pre; post_sru = sru;
    start = 1'b1;
    @(negedge clk3);
    start = 1'b0;
    run_cycles(guard, hold, lat);
  endtask

  int          lat;
  logic [19:0] t_vec;

  initial begin
    rsthold = 1'b1; start = 1'b0; opsel = 3'd0; src_raddr = 5'd0; dst_waddr = 5'd0;
    pre_action = 2'd0; post_sru = 1'b0;
    repeat (3) @(negedge clk3);
    check("reset_state", {15'b0, raddr, waddr, action, t34, busy, done}, {15'b0, IDLE_VEC});
    #1 rsthold = 1'b0;
    @(negedge clk3);

    // Basic transaction
    do_tx(3'b011, 5'b00101, 5'b01010, 2'b00, 1'b0, -1, 1'b0, lat);
    check("basic_latency", 32'(lat), 32'd12);
    check("basic_loadb", 32'({s_r[0], s_w[0]}), 32'({5'b00101, 5'b11000}));
    check("basic_op", 32'({s_r[4], s_r[7], s_w[4]}), 32'({5'b10011, 5'b10011, 5'b00000}));
    check("basic_store", 32'({s_r[8], s_w[11]}), 32'({5'b11000, 5'b01010}));
    @(negedge clk3);

    // Full transaction with CLL pre step and SRU post step
    do_tx(3'b101, 5'b00011, 5'b00110, 2'b10, 1'b1, -1, 1'b0, lat);
    check("full_latency", 32'(lat), 32'd20);
    check("full_pre_action", 32'({s_a[0], s_a[3], s_a[4]}), 32'({4'b0010, 4'b0010, 4'b0000}));
    check("full_post_action", 32'({s_a[16], s_a[19], s_r[16]}), 32'({4'b0111, 4'b0111, 5'b00000}));
    for (int c = 0; c < 20; c++) t_vec[19-c] = s_t[c];
    check("full_t34_pattern", 32'(t_vec), 32'h000CCCCC);
    @(negedge clk3);

    // Reserved pre_action behaves like none
    do_tx(3'b011, 5'b00101, 5'b01010, 2'b11, 1'b0, -1, 1'b0, lat);
    check("reserved_latency", 32'(lat), 32'd12);
    check("reserved_first_step", 32'({s_a[0], s_r[0]}), 32'({4'b0000, 5'b00101}));
    @(negedge clk3);

    // Busy guard: start pulsed during OP phase 2, then held on the done clock
    do_tx(3'b011, 5'b00101, 5'b01010, 2'b00, 1'b0, 6, 1'b1, lat);
    check("guard_latency", 32'(lat), 32'd12);
    opsel = 3'b001; src_raddr = 5'b10001; dst_waddr = ALU_REG; pre_action = 2'b00; post_sru = 1'b0;
    @(negedge clk3);
    start = 1'b0;
    run_cycles(-1, 1'b0, lat);
    check("b2b_start", 32'({s_b[0], s_r[0], s_w[0]}), 32'({1'b1, 5'b10001, 5'b11000}));
    check("b2b_store_alu_both", 32'({s_r[8], s_w[8]}), 32'({5'b11000, 5'b11000}));
    check("b2b_latency", 32'(lat), 32'd12);
    @(negedge clk3);

    // Reset in STORE phase 1 between edges
    opsel = 3'b011; src_raddr = 5'b00101; dst_waddr = 5'b01010; pre_action = 2'b00; post_sru = 1'b0;
    start = 1'b1;
    @(negedge clk3);
    start = 1'b0;
    repeat (9) @(negedge clk3);
    check("pre_reset_store", 32'({raddr, waddr}), 32'({5'b11000, 5'b01010}));
    #1 rsthold = 1'b1;
    #1 check("async_reset_idle", {15'b0, raddr, waddr, action, t34, busy, done}, {15'b0, IDLE_VEC});
    repeat (2) @(negedge clk3);
    #1 rsthold = 1'b0;
    repeat (4) begin
      @(negedge clk3);
      check("reset_no_done", 32'({done, busy}), 32'd0);
    end
    do_tx(3'b011, 5'b00101, 5'b01010, 2'b00, 1'b0, -1, 1'b0, lat);
    check("post_reset_latency", 32'(lat), 32'd12);

    // Randomized traffic, start pulses arriving in any state
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk3);
      start      = ($urandom_range(0, 3) == 0);
      opsel      = 3'($urandom);
      src_raddr  = 5'($urandom);
      dst_waddr  = ($urandom_range(0, 7) == 0) ? ALU_REG : 5'($urandom);
      pre_action = 2'($urandom);
      post_sru   = 1'($urandom);
    end
    @(negedge clk3);
    start = 1'b0;
    repeat (30) @(negedge clk3);
    check("model_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
